// File: rtl/conv_window_sched.sv
// Window scheduler for the KxK convolution datapath: raster-order window requests,
// credit-limited issue, and an in-order result FIFO with a valid/ready output.
module conv_window_sched #(
  parameter int KERNEL     = 3,
  parameter int AW         = 8,
  parameter int DW         = 11,
  parameter int LAT        = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] cfg_img_w,
  input  logic [AW-1:0] cfg_img_h,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic          win_req,
  output logic [AW-1:0] win_x,
  output logic [AW-1:0] win_y,
  input  logic          win_ack,
  output logic          conv_en_in,
  input  logic          conv_en_out,
  input  logic [DW-1:0] conv_d_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_last,
  output logic          proto_err,
  output logic [1:0]    state_dbg
);
  // Handshakes: a window transfers on win_req & win_ack; a result leaves the FIFO
  // on res_valid & res_ready. win_req never depends on win_ack, res_valid never on res_ready.

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(LAT + 1) + 1;
  localparam logic [AW-1:0]   K_VAL  = AW'(KERNEL);
  localparam logic [AW-1:0]   K_M1   = AW'(KERNEL - 1);
  localparam logic [AW-1:0]   ONE    = AW'(1);
  localparam logic [2*AW-1:0] ONE2   = {{(2*AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   FULL_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   ow, oh;
  logic [2*AW-1:0] total, push_count;
  logic [CW-1:0]   fifo_count;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [DW:0]     mem [FIFO_DEPTH];
  logic [DW:0]     head;
  logic [IW-1:0]   inflight;
  logic            dims_ok, start_ok, accept, row_end, last_win;
  logic            full, push, pop;

  assign dims_ok   = (cfg_img_w >= K_VAL) && (cfg_img_h >= K_VAL);
  assign start_ok  = (state == S_IDLE) && start && dims_ok;
  assign total     = {{AW{1'b0}}, ow} * {{AW{1'b0}}, oh};

  // Credits: FIFO slots already used plus results still inside the datapath.
  assign win_req    = (state == S_RUN) && ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));
  assign accept     = win_req && win_ack;
  assign conv_en_in = accept;
  assign row_end    = (win_x == ow - ONE);
  assign last_win   = row_end && (win_y == oh - ONE);

  assign full      = (fifo_count == FULL_C);
  assign res_valid = (fifo_count != '0);
  assign pop       = res_valid && res_ready;
  assign push      = conv_en_out && (!full || pop);
  assign head      = mem[rd_ptr];
  assign res_data  = res_valid ? head[DW-1:0] : '0;
  assign res_last  = res_valid && head[DW];

  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_RUN;
      S_RUN:   if (accept && last_win) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && head[DW]) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err    <= 1'b0;
      proto_err  <= 1'b0;
      ow         <= '0;
      oh         <= '0;
      win_x      <= '0;
      win_y      <= '0;
      push_count <= '0;
      inflight   <= '0;
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      cfg_err <= (state == S_IDLE) && start && !dims_ok;
      if (start_ok) begin
        ow         <= cfg_img_w - K_M1;
        oh         <= cfg_img_h - K_M1;
        win_x      <= '0;
        win_y      <= '0;
        push_count <= '0;
      end else if (accept) begin
        if (last_win) begin
          win_x <= '0;
          win_y <= '0;
        end else if (row_end) begin
          win_x <= '0;
          win_y <= win_y + ONE;
        end else begin
          win_x <= win_x + ONE;
        end
      end

      case ({accept, conv_en_out})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   if (inflight != '0) inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase

      // Sticky: a result nobody asked for, or one with nowhere to go.
      if (conv_en_out && ((inflight == '0) || (full && !pop))) proto_err <= 1'b1;

      if (push) begin
        wr_ptr     <= wr_ptr + PW'(1);
        push_count <= push_count + ONE2;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {(push_count == total - ONE2), conv_d_out};
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched: LAT=1 datapath model, random ack/ready, and a
// scoreboard of raster-order windows and results built from the image geometry.
module tb_conv_window_sched;
  localparam int KERNEL = 3;
  localparam int AW     = 8;
  localparam int DW     = 11;
  localparam int LAT    = 1;
  localparam int DEPTH  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_img_w = '0, cfg_img_h = '0;
  logic          busy, done, cfg_err, win_req, conv_en_in;
  logic [AW-1:0] win_x, win_y;
  logic          win_ack = 1'b0;
  logic          conv_en_out = 1'b0;
  logic [DW-1:0] conv_d_out = '0;
  logic          res_valid, res_last, proto_err;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic [1:0]    state_dbg;

  conv_window_sched #(.KERNEL(KERNEL), .AW(AW), .DW(DW), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
    .busy(busy), .done(done), .cfg_err(cfg_err), .win_req(win_req), .win_x(win_x),
    .win_y(win_y), .win_ack(win_ack), .conv_en_in(conv_en_in), .conv_en_out(conv_en_out),
    .conv_d_out(conv_d_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_last(res_last), .proto_err(proto_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DW:0]     exp_q[$];
  logic [2*AW-1:0] coord_q[$];
  int total = 0, bad = 0;
  int done_cnt = 0, acc_cnt = 0, pops = 0;
  int ack_pct = 100, ready_pct = 100, salt = 0;
  logic inject = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] res_fn(input int x, input int y, input int s);
    int v;
    v = x * 37 + y * 101 + s;
    return v[DW-1:0];
  endfunction

  // ---------------- environment drivers ----------------
  always @(posedge clk) begin
    #1;
    win_ack   = ($urandom_range(0, 99) < ack_pct);
    res_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // Datapath model: one cycle from conv_en_in to conv_en_out.
  always begin
    logic          nv;
    logic [DW-1:0] nd;
    @(negedge clk);
    nv = (conv_en_in && !rst) || inject;
    nd = inject ? DW'(11'h5a5) : res_fn(int'(win_x), int'(win_y), salt);
    @(posedge clk);
    #1;
    conv_en_out = nv;
    conv_d_out  = nv ? nd : '0;
  end

  // ---------------- monitor ----------------
  logic            prev_wait = 1'b0, last_prev = 1'b0;
  logic [2*AW-1:0] prev_xy = '0;

  always @(negedge clk) begin
    logic [DW:0] e;
    if (rst) begin
      prev_wait = 1'b0;
      last_prev = 1'b0;
    end else begin
      if (prev_wait && win_req) check("coord_hold", {win_y, win_x}, prev_xy);
      prev_wait = win_req && !win_ack;
      prev_xy   = {win_y, win_x};
      if (conv_en_in) begin
        acc_cnt++;
        check("win_expected", coord_q.size() != 0, 1);
        if (coord_q.size() != 0) check("win_xy", {win_y, win_x}, coord_q.pop_front());
      end
      if (done || last_prev) begin
        check("done_pulse", done, last_prev);
        if (done) begin
          check("busy_in_done", busy, 0);
          done_cnt++;
        end
      end
      last_prev = 1'b0;
      if (res_valid && res_ready) begin
        pops++;
        check("res_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result", {res_last, res_data}, e);
          last_prev = e[DW];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    coord_q.delete();
    @(negedge clk);
    check("reset_outputs", {busy, done, cfg_err, win_req, win_x, win_y, conv_en_in, res_valid,
                            res_data, res_last, proto_err, state_dbg}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_start(input int w, input int h);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_img_w = AW'(w);
    cfg_img_h = AW'(h);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_start(input int w, input int h);
    int ow, oh;
    logic [DW:0] e;
    salt = $urandom_range(0, 2047);
    ow = w - KERNEL + 1;
    oh = h - KERNEL + 1;
    for (int y = 0; y < oh; y++) begin
      for (int x = 0; x < ow; x++) begin
        coord_q.push_back({AW'(y), AW'(x)});
        e = {(x == ow - 1 && y == oh - 1), res_fn(x, y, salt)};
        exp_q.push_back(e);
      end
    end
    pulse_start(w, h);
    @(negedge clk);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string name);
    int base, t;
    base = done_cnt;
    t = 0;
    while (done_cnt == base && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done"}, done_cnt != base, 1);
    check({name, "_drained"}, exp_q.size() + coord_q.size(), 0);
    @(negedge clk);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int a0, base, t;
    apply_reset();

    // Basic 5x5 frame, free-flowing.
    ack_pct = 100; ready_pct = 100;
    do_start(5, 5);
    wait_done("basic");
    check("proto_err_basic", proto_err, 0);

    // Consumer stalled: issue stops at the credit limit.
    ready_pct = 0;
    a0 = acc_cnt;
    do_start(5, 5);
    repeat (20) @(negedge clk);
    check("credit_issue_count", acc_cnt - a0, DEPTH);
    check("credit_win_req_low", win_req, 0);
    check("credit_fifo_valid", res_valid, 1);
    ready_pct = 100;
    wait_done("backpressure");
    check("proto_err_bp", proto_err, 0);

    // Bad dimensions.
    base = acc_cnt;
    pulse_start(2, 8);
    @(negedge clk);
    check("cfg_err_pulse", cfg_err, 1);
    t = 0;
    repeat (10) begin
      @(negedge clk);
      t += int'(busy) + int'(win_req) + int'(cfg_err);
    end
    check("cfg_err_quiet", t, 0);
    check("cfg_err_no_issue", acc_cnt - base, 0);

    // 6x4 with sparse acks.
    ack_pct = 30;
    do_start(6, 4);
    wait_done("sparse_ack");

    // Random geometries and handshakes.
    for (int i = 0; i < 4; i++) begin
      ack_pct = $urandom_range(20, 100);
      ready_pct = $urandom_range(30, 100);
      do_start($urandom_range(3, 9), $urandom_range(3, 9));
      wait_done("random");
    end

    // Reset in the middle of a frame, then a clean frame.
    ack_pct = 100; ready_pct = 50;
    base = pops;
    do_start(5, 5);
    t = 0;
    while (pops < base + 3 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("midreset_reached_3", pops >= base + 3, 1);
    apply_reset();
    ready_pct = 100;
    do_start(5, 5);
    wait_done("after_reset");

    // Start while running is ignored.
    ready_pct = 60;
    base = done_cnt;
    do_start(6, 5);
    repeat (3) @(posedge clk);
    pulse_start(7, 7);
    @(negedge clk);
    check("restart_ignored_busy", busy, 1);
    wait_done("restart_ignored");
    repeat (20) @(negedge clk);
    check("restart_frame_count", done_cnt - base, 1);

    // Unsolicited result sets a sticky protocol error.
    ready_pct = 0;
    check("proto_err_clear", proto_err, 0);
    @(posedge clk); #1;
    inject = 1'b1;
    @(posedge clk); #2;
    inject = 1'b0;
    repeat (3) @(negedge clk);
    check("proto_err_set", proto_err, 1);
    repeat (10) @(negedge clk);
    check("proto_err_sticky", proto_err, 1);
    apply_reset();
    ready_pct = 100;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
